// File: rtl/voice_pkg.sv
// Shared constants and helpers for the per-voice oscillator.
package voice_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StDrain
    } state_e;

    localparam logic [1:0] WselSquare = 2'b00;
    localparam logic [1:0] WselSaw    = 2'b01;
    localparam logic [1:0] WselTri    = 2'b10;
    localparam logic [1:0] WselSine   = 2'b11;

    // Octave-7 phase increments, round(f * 2^24 / 40 kHz), C7..B7.
    localparam logic [23:0] TUNE7 [0:11] = '{
        24'd877868,  24'd930071,  24'd985419,  24'd1043969,
        24'd1106047, 24'd1171815, 24'd1241495, 24'd1315318,
        24'd1393531, 24'd1476395, 24'd1564186, 24'd1657197
    };

    // Quarter-wave sine magnitude above the 128 midpoint: round(127 * sin(2*pi*i/256)).
    localparam logic [7:0] SINE_Q [0:63] = '{
        8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd16,  8'd19,  8'd22,
        8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
        8'd49,  8'd51,  8'd54,  8'd57,  8'd60,  8'd63,  8'd65,  8'd68,
        8'd71,  8'd73,  8'd76,  8'd78,  8'd81,  8'd83,  8'd85,  8'd88,
        8'd90,  8'd92,  8'd94,  8'd96,  8'd98,  8'd100, 8'd102, 8'd104,
        8'd106, 8'd107, 8'd109, 8'd111, 8'd112, 8'd113, 8'd115, 8'd116,
        8'd117, 8'd118, 8'd120, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124,
        8'd125, 8'd125, 8'd126, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127
    };

    // A key code counts only when flagged valid and the semitone is in range.
    function automatic logic note_valid(input logic [7:0] code);
        return code[7] && (code[3:0] < 4'd12);
    endfunction

    // Octave-7 increment shifted down to the requested octave.
    function automatic logic [23:0] note_inc(input logic [7:0] code);
        logic [3:0] semi;
        semi = (code[3:0] < 4'd12) ? code[3:0] : 4'd0;
        return TUNE7[semi] >> (3'd7 - code[6:4]);
    endfunction

endpackage

// File: rtl/voice_oscillator_shaper.sv
// Combinational waveform map from the top 8 phase bits to an unsigned sample.
module wave_shaper
    import voice_pkg::*;
(
    input  logic [7:0] phase_hi_i,
    input  logic [1:0] wsel_i,
    output logic [7:0] wave_o
);

    logic [5:0] sine_idx;
    logic [7:0] sine_mag;

    // Select waveform; sine mirrors the quarter table on odd quadrants, inverts on the lower half.
    always_comb begin
        sine_idx = phase_hi_i[6] ? ~phase_hi_i[5:0] : phase_hi_i[5:0];
        sine_mag = SINE_Q[sine_idx];
        wave_o   = 8'h00;
        unique case (wsel_i)
            WselSquare: wave_o = phase_hi_i[7] ? 8'hFF : 8'h00;
            WselSaw:    wave_o = phase_hi_i;
            WselTri:    wave_o = phase_hi_i[7] ? ~{phase_hi_i[6:0], 1'b0}
                                               : {phase_hi_i[6:0], 1'b0};
            WselSine:   wave_o = phase_hi_i[7] ? (8'd127 - sine_mag) : (8'd128 + sine_mag);
            default:    wave_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/voice_oscillator.sv
// One piano voice: key code in, phase-accumulated 8-bit sample stream out.
module voice_oscillator
    import voice_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned PHASE_W    = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] note_code,
    input  logic [1:0] wsel,
    output logic [7:0] wave,
    output logic       sample_valid,
    output logic       key_on,
    output logic       key_off,
    output logic       active
);

    localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CntW-1:0]    cnt_q, cnt_d;
    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] inc_q, inc_d;
    logic [7:0]         note_q, note_d;
    logic [7:0]         wave_q, wave_d;
    logic               valid_q, valid_d;
    logic               key_on_q, key_on_d;
    logic               key_off_q, key_off_d;

    logic               tick;
    logic               code_ok;
    logic [PHASE_W-1:0] new_inc;
    logic [PHASE_W:0]   sum;
    logic [7:0]         shaped;

    assign tick    = (cnt_q == CntW'(SAMPLE_DIV - 1));
    assign code_ok = note_valid(note_code);
    assign new_inc = PHASE_W'(note_inc(note_code));
    assign sum     = {1'b0, phase_q} + {1'b0, inc_q};

    wave_shaper u_shaper (
        .phase_hi_i (phase_d[PHASE_W-1 -: 8]),
        .wsel_i     (wsel),
        .wave_o     (shaped)
    );

    // Voice FSM, phase accumulation and output staging; everything advances on ticks only.
    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        state_d   = state_q;
        phase_d   = phase_q;
        inc_d     = inc_q;
        note_d    = note_q;
        wave_d    = wave_q;
        valid_d   = tick;
        key_on_d  = 1'b0;
        key_off_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (code_ok) begin
                        state_d  = StPlay;
                        note_d   = note_code;
                        inc_d    = new_inc;
                        phase_d  = new_inc;
                        key_on_d = 1'b1;
                    end
                end
                StPlay: begin
                    if (code_ok && (note_code[6:0] != note_q[6:0])) begin
                        // Note change: new pitch takes effect at once, phase stays continuous.
                        note_d   = note_code;
                        inc_d    = new_inc;
                        phase_d  = phase_q + new_inc;
                        key_on_d = 1'b1;
                    end else if (code_ok) begin
                        phase_d = sum[PHASE_W-1:0];
                    end else begin
                        state_d   = StDrain;
                        phase_d   = sum[PHASE_W-1:0];
                        key_off_d = 1'b1;
                    end
                end
                StDrain: begin
                    // A re-press wins over the wrap check.
                    if (code_ok) begin
                        state_d  = StPlay;
                        note_d   = note_code;
                        inc_d    = new_inc;
                        phase_d  = phase_q + new_inc;
                        key_on_d = 1'b1;
                    end else if (sum[PHASE_W]) begin
                        state_d = StIdle;
                        phase_d = '0;
                    end else begin
                        phase_d = sum[PHASE_W-1:0];
                    end
                end
                default: begin
                    state_d = StIdle;
                    phase_d = '0;
                end
            endcase
            wave_d = (state_d == StIdle) ? 8'h00 : shaped;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            state_q   <= StIdle;
            phase_q   <= '0;
            inc_q     <= '0;
            note_q    <= '0;
            wave_q    <= '0;
            valid_q   <= 1'b0;
            key_on_q  <= 1'b0;
            key_off_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            inc_q     <= inc_d;
            note_q    <= note_d;
            wave_q    <= wave_d;
            valid_q   <= valid_d;
            key_on_q  <= key_on_d;
            key_off_q <= key_off_d;
        end
    end

    assign wave         = wave_q;
    assign sample_valid = valid_q;
    assign key_on       = key_on_q;
    assign key_off      = key_off_q;
    assign active       = (state_q != StIdle);

endmodule

// File: tb/tb_voice_oscillator.sv
// Scoreboard bench for voice_oscillator with a shortened sample divider.
module tb_voice_oscillator;

    localparam int unsigned Div  = 8;
    localparam longint unsigned Wrap = 64'd1 << 24;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] note_code;
    logic [1:0] wsel;
    logic [7:0] wave;
    logic       sample_valid;
    logic       key_on;
    logic       key_off;
    logic       active;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct packed {
        logic [7:0] wave;
        logic       kon;
        logic       koff;
        logic       act;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state: 0 idle, 1 play, 2 drain.
    int          m_state = 0;
    int unsigned m_cnt   = 0;
    logic [23:0] m_phase = '0;
    logic [23:0] m_inc   = '0;
    logic [7:0]  m_note  = '0;

    voice_oscillator #(
        .SAMPLE_DIV (Div),
        .PHASE_W    (24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .note_code    (note_code),
        .wsel         (wsel),
        .wave         (wave),
        .sample_valid (sample_valid),
        .key_on       (key_on),
        .key_off      (key_off),
        .active       (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] tune7(input int unsigned s);
        case (s)
            0:       return 24'd877868;
            1:       return 24'd930071;
            2:       return 24'd985419;
            3:       return 24'd1043969;
            4:       return 24'd1106047;
            5:       return 24'd1171815;
            6:       return 24'd1241495;
            7:       return 24'd1315318;
            8:       return 24'd1393531;
            9:       return 24'd1476395;
            10:      return 24'd1564186;
            default: return 24'd1657197;
        endcase
    endfunction

    function automatic logic [7:0] sine_ref(input logic [7:0] p);
        int unsigned i;
        real         r;
        int unsigned s;
        i = p[5:0];
        if (p[6]) i = 63 - i;
        r = 127.0 * $sin(3.14159265358979 * i / 128.0);
        s = $rtoi(r + 0.5);
        return p[7] ? 8'(127 - s) : 8'(128 + s);
    endfunction

    function automatic logic [7:0] shape(input logic [7:0] p, input logic [1:0] ws);
        case (ws)
            2'b00:   return p[7] ? 8'd255 : 8'd0;
            2'b01:   return p;
            2'b10:   return p[7] ? 8'(255 - 2 * p[6:0]) : 8'(2 * p[6:0]);
            default: return sine_ref(p);
        endcase
    endfunction

    // Reference model: evaluates each tick and pushes the expected sample.
    initial begin : model
        logic        ok;
        logic [23:0] inc;
        logic [24:0] s;
        exp_t        e;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_cnt = 0; m_state = 0; m_phase = '0; m_inc = '0; m_note = '0;
                sb_q.delete();
            end else if (m_cnt == Div - 1) begin
                m_cnt  = 0;
                ok     = note_code[7] && (note_code[3:0] < 12);
                inc    = tune7(note_code[3:0]) >> (7 - note_code[6:4]);
                s      = {1'b0, m_phase} + {1'b0, m_inc};
                e.kon  = 1'b0;
                e.koff = 1'b0;
                if (m_state == 0) begin
                    if (ok) begin
                        m_state = 1; m_note = note_code; m_inc = inc; m_phase = inc; e.kon = 1'b1;
                    end
                end else if (m_state == 1) begin
                    if (ok && note_code[6:0] != m_note[6:0]) begin
                        m_note = note_code; m_inc = inc; m_phase = m_phase + inc; e.kon = 1'b1;
                    end else if (ok) begin
                        m_phase = s[23:0];
                    end else begin
                        m_state = 2; m_phase = s[23:0]; e.koff = 1'b1;
                    end
                end else begin
                    if (ok) begin
                        m_state = 1; m_note = note_code; m_inc = inc; m_phase = m_phase + inc;
                        e.kon = 1'b1;
                    end else if (s >= 25'(Wrap)) begin
                        m_state = 0; m_phase = '0;
                    end else begin
                        m_phase = s[23:0];
                    end
                end
                e.act  = (m_state != 0);
                e.wave = (m_state == 0) ? 8'd0 : shape(m_phase[23:16], wsel);
                sb_q.push_back(e);
            end else begin
                m_cnt++;
            end
        end
    end

    // Scoreboard: every cycle the strobe must match, and each strobe must match its entry.
    initial begin : scoreboard
        exp_t e;
        forever begin
            @(negedge clk);
            check("strobe", sample_valid, sb_q.size() != 0);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_wave", wave, e.wave);
                check("sb_key_on", key_on, e.kon);
                check("sb_key_off", key_off, e.koff);
                check("sb_active", active, e.act);
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic next_strobe();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * Div; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("strobe_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : stim
        int unsigned idx;
        int unsigned wrap_n;
        int unsigned kon_cnt;
        int unsigned n;

        reset     = 1'b1;
        note_code = 8'h00;
        wsel      = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_wave", wave, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_key_on", key_on, 0);
        check("rst_key_off", key_off, 0);
        check("rst_active", active, 0);
        reset = 1'b0;

        // A4 saw.
        note_code = 8'hC9;
        wsel      = 2'b01;
        next_strobe();
        check("a4_key_on", key_on, 1);
        check("a4_wave1", wave, (24'd1476395 >> 3) >> 16);
        check("a4_active", active, 1);
        next_strobe();
        check("a4_wave2", wave, 5);
        check("a4_key_on2", key_on, 0);

        // Invalid semitone from idle.
        do_reset();
        note_code = 8'hCC;
        next_strobe();
        check("inv_wave", wave, 0);
        check("inv_key_on", key_on, 0);
        check("inv_active", active, 0);

        // Release drain, C0 square.
        do_reset();
        note_code = 8'h80;
        wsel      = 2'b00;
        next_strobe();
        check("c0_key_on", key_on, 1);
        repeat (3) next_strobe();
        note_code = 8'h00;
        next_strobe();
        idx = 5;
        check("drain_key_off", key_off, 1);
        check("drain_active", active, 1);
        for (int i = 0; i < 3000; i++) begin
            next_strobe();
            idx++;
            if (active !== 1'b1) break;
        end
        wrap_n = (32'(Wrap) + 6858 - 1) / 6858;
        check("drain_len", idx, wrap_n);
        check("drain_wave", wave, 0);
        check("drain_active_end", active, 0);

        // Note change in play.
        do_reset();
        note_code = 8'hC0;
        wsel      = 2'b01;
        repeat (3) next_strobe();
        note_code = 8'hC2;
        next_strobe();
        check("chg_key_on", key_on, 1);
        check("chg_wave", wave, (3 * (877868 >> 3) + (985419 >> 3)) >> 16);
        kon_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            next_strobe();
            if (key_on === 1'b1) kon_cnt++;
        end
        check("chg_single_pulse", kon_cnt, 0);

        // Re-press in drain.
        note_code = 8'h00;
        next_strobe();
        check("rp_key_off", key_off, 1);
        next_strobe();
        note_code = 8'hC2;
        next_strobe();
        check("rp_key_on", key_on, 1);
        check("rp_key_off_low", key_off, 0);
        check("rp_active", active, 1);

        // Mixed codes and waveforms, scoreboard only.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                note_code = {1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                             4'($urandom_range(0, 13))};
            end
            wsel = 2'($urandom_range(0, 3));
            next_strobe();
        end

        // Reset mid-play for one clock.
        note_code = 8'hC9;
        wsel      = 2'b11;
        repeat (2) next_strobe();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_wave", wave, 0);
        check("mid_rst_valid", sample_valid, 0);
        check("mid_rst_key_on", key_on, 0);
        check("mid_rst_key_off", key_off, 0);
        check("mid_rst_active", active, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sample_valid !== 1'b1 && n < 4 * Div);
        check("mid_rst_restart", n, Div);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
